// File: rtl/color_pkg.sv
// -----------------------------------------------------------------------------
// color_pkg
//
// Shared definitions for the camera color-detection path.
//
// Contents:
//   COLOR_NONE / COLOR_RED / COLOR_BLUE  2-bit result codes driven on COLOR
//   state_t                              frame sequencer state encoding
//   DEF_*                                default thresholds and counter width
// -----------------------------------------------------------------------------
package color_pkg;

  // Result codes presented to the Arduino interface.
  localparam logic [1:0] COLOR_NONE = 2'b00;
  localparam logic [1:0] COLOR_RED  = 2'b01;
  localparam logic [1:0] COLOR_BLUE = 2'b10;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // waiting for a VSYNC rising edge (frame start)
    COUNT  = 2'd1,  // accumulating red/blue pixels of the current frame
    DECIDE = 2'd2   // single cycle: latch counts and publish the decision
  } state_t;

  // Defaults. 15 bits holds a full 176x144 frame (25344 pixels).
  localparam int         DEF_CNT_W      = 15;
  localparam logic [2:0] DEF_RED_THR    = 3'd4;
  localparam logic [1:0] DEF_BLUE_THR   = 2'd2;
  localparam int         DEF_MIN_PIXELS = 2000;

endpackage

// File: rtl/pixel_classifier.sv
// -----------------------------------------------------------------------------
// pixel_classifier
//
// Purely combinational RGB332 classifier.
//
// Ports:
//   pixel_data  in  8  RGB332 pixel: R[7:5], G[4:2], B[1:0]
//   red_thr     in  3  minimum R for a red pixel
//   blue_thr    in  2  minimum B for a blue pixel
//   is_red      out 1  R >= red_thr and B <= 1
//   is_blue     out 1  B >= blue_thr and R <= 3
//
// The green field takes no part in the decision. The cross-conditions
// (little blue for red, little red for blue) reject white/magenta pixels
// that would otherwise satisfy both thresholds.
// -----------------------------------------------------------------------------
module pixel_classifier (
  input  logic [7:0] pixel_data,
  input  logic [2:0] red_thr,
  input  logic [1:0] blue_thr,
  output logic       is_red,
  output logic       is_blue
);

  logic [2:0] r_field;
  logic [1:0] b_field;
  logic       unused_green;

  assign r_field = pixel_data[7:5];
  assign b_field = pixel_data[1:0];

  // Green is intentionally ignored.
  assign unused_green = ^pixel_data[4:2];

  assign is_red  = (r_field >= red_thr)  && (b_field <= 2'd1);
  assign is_blue = (b_field >= blue_thr) && (r_field <= 3'd3);

endmodule

// File: rtl/color_frame_controller.sv
// -----------------------------------------------------------------------------
// color_frame_controller
//
// Frame-level sequencer between the OV7670 RGB332 pixel stream and the
// Arduino interface. Counts red and blue pixels per frame (bracketed by
// VGA_VSYNC_NEG), picks the dominant color at frame end and offers it to the
// consumer with a RESULT_VALID / RESULT_ACK handshake.
//
// Parameters:
//   CNT_W       width of the per-frame pixel counters
//   RED_THR     minimum R[2:0] for a red pixel
//   BLUE_THR    minimum B[1:0] for a blue pixel
//   MIN_PIXELS  minimum winning count for a non-NONE decision
//
// Ports:
//   CLK            in   1      system clock, rising edge
//   RESET          in   1      synchronous active-high reset
//   VGA_VSYNC_NEG  in   1      low during vertical sync
//   PIXEL_VALID    in   1      PIXEL_DATA holds a pixel this cycle
//   PIXEL_DATA     in   8      RGB332 pixel
//   RESULT_ACK     in   1      consumer accepts the current result
//   COLOR          out  2      00 NONE, 01 RED, 10 BLUE
//   RESULT_VALID   out  1      COLOR holds an unacknowledged result
//   RED_COUNT      out  CNT_W  red count of the last completed frame
//   BLUE_COUNT     out  CNT_W  blue count of the last completed frame
//   BUSY           out  1      a frame is being accumulated
//   OVERRUN        out  1      sticky: a result was overwritten un-acked
//
// Build option:
//   FRAME_VOTE_EN  when defined, a result is published only when two
//                  consecutive frames produce the same decision.
// -----------------------------------------------------------------------------
module color_frame_controller
  import color_pkg::*;
#(
  parameter int               CNT_W      = DEF_CNT_W,
  parameter logic [2:0]       RED_THR    = DEF_RED_THR,
  parameter logic [1:0]       BLUE_THR   = DEF_BLUE_THR,
  parameter logic [CNT_W-1:0] MIN_PIXELS = CNT_W'(DEF_MIN_PIXELS)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             VGA_VSYNC_NEG,
  input  logic             PIXEL_VALID,
  input  logic [7:0]       PIXEL_DATA,
  input  logic             RESULT_ACK,
  output logic [1:0]       COLOR,
  output logic             RESULT_VALID,
  output logic [CNT_W-1:0] RED_COUNT,
  output logic [CNT_W-1:0] BLUE_COUNT,
  output logic             BUSY,
  output logic             OVERRUN
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t           state_reg;
  logic             vsync_d1_reg;
  logic             vsync_d2_reg;
  logic [CNT_W-1:0] red_acc_reg;
  logic [CNT_W-1:0] blue_acc_reg;
  logic [1:0]       color_reg;
  logic             result_valid_reg;
  logic [CNT_W-1:0] red_count_reg;
  logic [CNT_W-1:0] blue_count_reg;
  logic             busy_reg;
  logic             overrun_reg;

`ifdef FRAME_VOTE_EN
  logic [1:0]       cand_color_reg;
  logic             cand_valid_reg;
`endif

  // ---------------------------------------------------------------------------
  // Pixel classification
  // ---------------------------------------------------------------------------
  logic pix_is_red;
  logic pix_is_blue;

  pixel_classifier u_classifier (
    .pixel_data (PIXEL_DATA),
    .red_thr    (RED_THR),
    .blue_thr   (BLUE_THR),
    .is_red     (pix_is_red),
    .is_blue    (pix_is_blue)
  );

  // ---------------------------------------------------------------------------
  // VSYNC edge detection on a two-stage registered copy. Working from the
  // registered copies puts DECIDE one cycle after the first low sample and
  // the published result one cycle after that. Both stages reset high so
  // that a VSYNC already high when reset drops is not taken as a frame start:
  // the first frame after reset is always a complete one.
  // ---------------------------------------------------------------------------
  logic frame_start;
  logic frame_end;

  assign frame_start =  vsync_d1_reg & ~vsync_d2_reg;
  assign frame_end   = ~vsync_d1_reg &  vsync_d2_reg;

  // Pixels are counted only while the live VSYNC sample is high, so any
  // pixel presented on or after the first low sample is dropped.
  logic count_pixel;
  assign count_pixel = PIXEL_VALID & VGA_VSYNC_NEG;

  // ---------------------------------------------------------------------------
  // Decision on the current accumulators. Strict comparisons make a tie NONE.
  // ---------------------------------------------------------------------------
  logic [1:0] decision;

  always_comb begin
    decision = COLOR_NONE;
    if ((red_acc_reg > blue_acc_reg) && (red_acc_reg >= MIN_PIXELS)) begin
      decision = COLOR_RED;
    end else if ((blue_acc_reg > red_acc_reg) && (blue_acc_reg >= MIN_PIXELS)) begin
      decision = COLOR_BLUE;
    end
  end

  // Whether the decision made in DECIDE is handed to the consumer.
  logic publish;

`ifdef FRAME_VOTE_EN
  assign publish = cand_valid_reg && (cand_color_reg == decision);
`else
  assign publish = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Frame sequencer, accumulators and result handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg        <= IDLE;
      vsync_d1_reg     <= 1'b1;
      vsync_d2_reg     <= 1'b1;
      red_acc_reg      <= '0;
      blue_acc_reg     <= '0;
      color_reg        <= COLOR_NONE;
      result_valid_reg <= 1'b0;
      red_count_reg    <= '0;
      blue_count_reg   <= '0;
      busy_reg         <= 1'b0;
      overrun_reg      <= 1'b0;
`ifdef FRAME_VOTE_EN
      cand_color_reg   <= COLOR_NONE;
      cand_valid_reg   <= 1'b0;
`endif
    end else begin
      vsync_d1_reg <= VGA_VSYNC_NEG;
      vsync_d2_reg <= vsync_d1_reg;

      // Acknowledge; a publish in DECIDE below takes priority over this.
      if (RESULT_ACK && result_valid_reg) begin
        result_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          // A falling edge here belongs to a frame we never saw start.
          if (frame_start) begin
            red_acc_reg  <= '0;
            blue_acc_reg <= '0;
            state_reg    <= COUNT;
            busy_reg     <= 1'b1;
          end
        end

        COUNT: begin
          if (frame_start) begin
            // A fresh frame start mid-count discards the partial frame.
            red_acc_reg  <= '0;
            blue_acc_reg <= '0;
          end else begin
            if (count_pixel && pix_is_red && (red_acc_reg != CNT_MAX)) begin
              red_acc_reg <= red_acc_reg + CNT_ONE;
            end
            if (count_pixel && pix_is_blue && (blue_acc_reg != CNT_MAX)) begin
              blue_acc_reg <= blue_acc_reg + CNT_ONE;
            end
            if (frame_end) begin
              state_reg <= DECIDE;
              busy_reg  <= 1'b0;
            end
          end
        end

        DECIDE: begin
          red_count_reg  <= red_acc_reg;
          blue_count_reg <= blue_acc_reg;
          if (publish) begin
            color_reg        <= decision;
            result_valid_reg <= 1'b1;
            // Same-cycle ack means the old result was consumed: no overrun.
            if (result_valid_reg && !RESULT_ACK) begin
              overrun_reg <= 1'b1;
            end
          end
`ifdef FRAME_VOTE_EN
          cand_color_reg <= decision;
          cand_valid_reg <= 1'b1;
`endif
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign COLOR        = color_reg;
  assign RESULT_VALID = result_valid_reg;
  assign RED_COUNT    = red_count_reg;
  assign BLUE_COUNT   = blue_count_reg;
  assign BUSY         = busy_reg;
  assign OVERRUN      = overrun_reg;

endmodule

// File: tb/tb_color_frame_controller.sv
`timescale 1ns/1ps
module tb_color_frame_controller;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        VGA_VSYNC_NEG;
  logic        PIXEL_VALID;
  logic [7:0]  PIXEL_DATA;
  logic        RESULT_ACK;

  logic [1:0]  COLOR;
  logic        RESULT_VALID;
  logic [14:0] RED_COUNT;
  logic [14:0] BLUE_COUNT;
  logic        BUSY;
  logic        OVERRUN;

  logic [1:0]  sat_color;
  logic        sat_valid;
  logic [3:0]  sat_red;
  logic [3:0]  sat_blue;
  logic        sat_busy;
  logic        sat_ovr;

  always #5 CLK = ~CLK;

  color_frame_controller dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .VGA_VSYNC_NEG (VGA_VSYNC_NEG),
    .PIXEL_VALID   (PIXEL_VALID),
    .PIXEL_DATA    (PIXEL_DATA),
    .RESULT_ACK    (RESULT_ACK),
    .COLOR         (COLOR),
    .RESULT_VALID  (RESULT_VALID),
    .RED_COUNT     (RED_COUNT),
    .BLUE_COUNT    (BLUE_COUNT),
    .BUSY          (BUSY),
    .OVERRUN       (OVERRUN)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  color_frame_controller #(
    .CNT_W      (4),
    .MIN_PIXELS (4'd5)
  ) dut_sat (
    .CLK           (CLK),
    .RESET         (RESET),
    .VGA_VSYNC_NEG (VGA_VSYNC_NEG),
    .PIXEL_VALID   (PIXEL_VALID),
    .PIXEL_DATA    (PIXEL_DATA),
    .RESULT_ACK    (RESULT_ACK),
    .COLOR         (sat_color),
    .RESULT_VALID  (sat_valid),
    .RED_COUNT     (sat_red),
    .BLUE_COUNT    (sat_blue),
    .BUSY          (sat_busy),
    .OVERRUN       (sat_ovr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         n_a;
    logic [7:0] pix_a;
    int         n_b;
    logic [7:0] pix_b;
    int         n_inv;      // red pixels with PIXEL_VALID low
    bit         do_ack;     // pulse RESULT_ACK after checking
    logic [1:0] exp_color;
    int         exp_red;
    int         exp_blue;
    bit         exp_valid;
    bit         exp_ovr;
    int         sat_red;
    int         sat_blue;
    logic [1:0] sat_color;
  } frame_vec_t;

  frame_vec_t vecs[$];
  frame_vec_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_pixels(input int n, input logic [7:0] pix, input logic vld);
    for (int i = 0; i < n; i++) begin
      PIXEL_VALID = vld;
      PIXEL_DATA  = pix;
      tick();
    end
    PIXEL_VALID = 1'b0;
  endtask

  // Raise VSYNC and give the edge detector time to enter COUNT.
  task automatic frame_open();
    VGA_VSYNC_NEG = 1'b1;
    repeat (4) tick();
  endtask

  // Drop VSYNC while still presenting red pixels (must not be counted),
  // walk through t, t+1, t+2 and return just after edge t+2.
  task automatic frame_close(input bit ack_at_decide, input bit busy_exp);
    VGA_VSYNC_NEG = 1'b0;
    PIXEL_VALID   = 1'b1;
    PIXEL_DATA    = 8'hE0;
    tick();                                   // edge t
    check("busy_at_t", BUSY, busy_exp);
    check("sat_busy_at_t", sat_busy, busy_exp);
    tick();                                   // edge t+1
    check("busy_at_t1", BUSY, 0);
    PIXEL_VALID = 1'b0;
    if (ack_at_decide) RESULT_ACK = 1'b1;
    tick();                                   // edge t+2
    RESULT_ACK = 1'b0;
  endtask

  task automatic ack_pulse(input logic [1:0] color_exp, input bit ovr_exp);
    RESULT_ACK = 1'b1;
    tick();
    RESULT_ACK = 1'b0;
    check("valid_after_ack", RESULT_VALID, 0);
    check("color_held_after_ack", COLOR, color_exp);
    check("ovr_after_ack", OVERRUN, ovr_exp);
    $display("ack: valid=%0d color=%0d overrun=%0d", RESULT_VALID, COLOR, OVERRUN);
  endtask

  initial begin
    #3ms;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
`ifdef FRAME_VOTE_EN
    vecs.push_back(frame_vec_t'{3000, 8'hE0, 0, 8'h00, 0, 1'b0, 2'b00, 3000, 0,    1'b0, 1'b0, 15, 0,  2'b00});
    vecs.push_back(frame_vec_t'{2100, 8'h03, 0, 8'h00, 0, 1'b0, 2'b00, 0,    2100, 1'b0, 1'b0, 0,  15, 2'b00});
    vecs.push_back(frame_vec_t'{2100, 8'h03, 0, 8'h00, 0, 1'b1, 2'b10, 0,    2100, 1'b1, 1'b0, 0,  15, 2'b10});
`else
    vecs.push_back(frame_vec_t'{3000, 8'hE0, 500,  8'h03, 0,   1'b1, 2'b01, 3000, 500,  1'b1, 1'b0, 15, 15, 2'b00});
    vecs.push_back(frame_vec_t'{2500, 8'h80, 2500, 8'h62, 0,   1'b1, 2'b00, 2500, 2500, 1'b1, 1'b0, 15, 15, 2'b00});
    vecs.push_back(frame_vec_t'{1500, 8'h03, 0,    8'h00, 700, 1'b1, 2'b00, 0,    1500, 1'b1, 1'b0, 0,  15, 2'b10});
    vecs.push_back(frame_vec_t'{2000, 8'h62, 100,  8'hFF, 0,   1'b1, 2'b10, 0,    2000, 1'b1, 1'b0, 0,  15, 2'b10});
    vecs.push_back(frame_vec_t'{1999, 8'h80, 300,  8'h82, 0,   1'b1, 2'b00, 1999, 0,    1'b1, 1'b0, 15, 0,  2'b01});
    vecs.push_back(frame_vec_t'{20,   8'hE0, 0,    8'h00, 0,   1'b1, 2'b00, 20,   0,    1'b1, 1'b0, 15, 0,  2'b01});
    vecs.push_back(frame_vec_t'{2100, 8'h03, 0,    8'h00, 0,   1'b0, 2'b10, 0,    2100, 1'b1, 1'b0, 0,  15, 2'b10});
    vecs.push_back(frame_vec_t'{2200, 8'h03, 0,    8'h00, 0,   1'b1, 2'b10, 0,    2200, 1'b1, 1'b1, 0,  15, 2'b10});
`endif

    RESET         = 1'b1;
    VGA_VSYNC_NEG = 1'b0;
    PIXEL_VALID   = 1'b0;
    PIXEL_DATA    = 8'h00;
    RESULT_ACK    = 1'b0;
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    check("reset_color", COLOR, 0);
    check("reset_valid", RESULT_VALID, 0);
    check("reset_red", RED_COUNT, 0);
    check("reset_blue", BLUE_COUNT, 0);
    check("reset_busy", BUSY, 0);
    check("reset_ovr", OVERRUN, 0);
    $display("reset: color=%0d valid=%0d busy=%0d overrun=%0d", COLOR, RESULT_VALID, BUSY, OVERRUN);

    // Table-driven frames through the scoreboard.
    for (int i = 0; i < vecs.size(); i++) begin
      frame_vec_t v;
      frame_vec_t e;
      v = vecs[i];
      frame_open();
      sb_q.push_back(v);
      send_pixels(v.n_a, v.pix_a, 1'b1);
      send_pixels(v.n_b, v.pix_b, 1'b1);
      send_pixels(v.n_inv, 8'hE0, 1'b0);
      frame_close(1'b0, 1'b1);
      e = sb_q.pop_front();
      check("frame_color", COLOR, e.exp_color);
      check("frame_red", RED_COUNT, e.exp_red);
      check("frame_blue", BLUE_COUNT, e.exp_blue);
      check("frame_valid", RESULT_VALID, e.exp_valid);
      check("frame_ovr", OVERRUN, e.exp_ovr);
      check("sat_red", sat_red, e.sat_red);
      check("sat_blue", sat_blue, e.sat_blue);
      check("sat_color", sat_color, e.sat_color);
      check("sat_valid", sat_valid, e.exp_valid);
      check("sat_ovr", sat_ovr, e.exp_ovr);
      $display("frame %0d: color=%0d red=%0d blue=%0d valid=%0d overrun=%0d sat_red=%0d sat_blue=%0d",
               i, COLOR, RED_COUNT, BLUE_COUNT, RESULT_VALID, OVERRUN, sat_red, sat_blue);
      if (e.do_ack) ack_pulse(e.exp_color, e.exp_ovr);
    end

`ifndef FRAME_VOTE_EN
    // Reset in the middle of a frame.
    frame_open();
    send_pixels(1000, 8'hE0, 1'b1);
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    check("midrst_color", COLOR, 0);
    check("midrst_valid", RESULT_VALID, 0);
    check("midrst_red", RED_COUNT, 0);
    check("midrst_blue", BLUE_COUNT, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_ovr", OVERRUN, 0);
    check("midrst_sat_red", sat_red, 0);
    $display("mid-frame reset: color=%0d valid=%0d busy=%0d", COLOR, RESULT_VALID, BUSY);

    // Falling edge of the interrupted frame must not produce a result.
    frame_close(1'b0, 1'b0);
    check("orphan_valid", RESULT_VALID, 0);
    check("orphan_red", RED_COUNT, 0);
    $display("orphan frame end: valid=%0d red=%0d", RESULT_VALID, RED_COUNT);

    // First full frame after reset.
    frame_open();
    send_pixels(3000, 8'hE0, 1'b1);
    frame_close(1'b0, 1'b1);
    check("postrst_color", COLOR, 2'b01);
    check("postrst_valid", RESULT_VALID, 1);
    check("postrst_red", RED_COUNT, 3000);
    check("postrst_blue", BLUE_COUNT, 0);
    check("postrst_ovr", OVERRUN, 0);
    $display("post-reset frame: color=%0d valid=%0d red=%0d", COLOR, RESULT_VALID, RED_COUNT);

    // New decision and RESULT_ACK on the same edge: decision wins, no overrun.
    frame_open();
    send_pixels(2100, 8'h03, 1'b1);
    frame_close(1'b1, 1'b1);
    check("sameack_color", COLOR, 2'b10);
    check("sameack_valid", RESULT_VALID, 1);
    check("sameack_ovr", OVERRUN, 0);
    check("sameack_blue", BLUE_COUNT, 2100);
    $display("same-cycle ack frame: color=%0d valid=%0d overrun=%0d", COLOR, RESULT_VALID, OVERRUN);
    ack_pulse(2'b10, 1'b0);

    // An ack with nothing pending changes nothing.
    ack_pulse(2'b10, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
